// File: rtl/instruction_buffer_if.sv
// Bundle of handshake signals around the instruction buffer.
//   Decode side  : if_valid, if_packet  -> buffer ; ib_ready <- buffer
//   Dispatch side: rob_dp_available, rs_available -> buffer ;
//                  dp_packet, dp_rob_available, dp_fire <- buffer
// The buffer connects through the slave modport. The decode/dispatch
// environment connects through the master modport.
interface instruction_buffer_if #(
  parameter int PKT_W = 32
);
  logic             if_valid;
  logic [PKT_W-1:0] if_packet;
  logic             ib_ready;
  logic [1:0]       rob_dp_available;
  logic             rs_available;
  logic [PKT_W-1:0] dp_packet;
  logic [1:0]       dp_rob_available;
  logic             dp_fire;

  modport master (
    output if_valid, if_packet, rob_dp_available, rs_available,
    input  ib_ready, dp_packet, dp_rob_available, dp_fire
  );

  modport slave (
    input  if_valid, if_packet, rob_dp_available, rs_available,
    output ib_ready, dp_packet, dp_rob_available, dp_fire
  );
endinterface

// File: rtl/instruction_buffer.sv
// Circular FIFO of decoded instruction packets sitting between decode and
// dispatch. The oldest entry is presented show-ahead on dp_packet. It is
// dequeued only when both the ROB and the reservation stations have room.
// A squash empties the buffer in a single cycle.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   squash       : flush all entries (mispredict / exception)
//   bus          : decode and dispatch handshakes (slave modport)
//   ib_count     : current occupancy
//   full, empty  : occupancy flags
//   ovf_err      : sticky, decode presented a packet while not ready
module instruction_buffer #(
  parameter int IB_SZ = 8,
  parameter int CNT_W = $clog2(IB_SZ) + 1,
  parameter int PKT_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 squash,
  instruction_buffer_if.slave  bus,
  output logic [CNT_W-1:0]     ib_count,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf_err
);
  localparam int PTR_W = $clog2(IB_SZ);

  logic [PKT_W-1:0] mem [IB_SZ];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             enq;
  logic             fire;

  assign full  = (count == CNT_W'(IB_SZ));
  assign empty = (count == '0);

  // Readiness uses only the registered occupancy. A dequeue in the same
  // cycle does not open a slot, which keeps decode off the dispatch path.
  assign bus.ib_ready = !full && !squash;
  assign enq          = bus.if_valid && bus.ib_ready;

  assign fire = !empty && !squash && bus.rs_available &&
                (bus.rob_dp_available != 2'b00);

  assign bus.dp_fire          = fire;
  assign bus.dp_rob_available = {1'b0, fire};
  // The packet is forced to zero when empty, so its valid bit reads 0.
  assign bus.dp_packet        = empty ? '0 : mem[head];

  assign ib_count = count;
  assign ovf_err  = ovf;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < IB_SZ; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (bus.if_valid && !bus.ib_ready && !squash) begin
        ovf <= 1'b1;
      end
      if (squash) begin
        // Memory is left stale, because the pointers alone define the contents.
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (enq) begin
          mem[tail] <= bus.if_packet;
          tail      <= tail + PTR_W'(1);
        end
        if (fire) begin
          head <= head + PTR_W'(1);
        end
        case ({enq, fire})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instruction_buffer.sv
// Self-checking bench for instruction_buffer. A queue-based reference model
// predicts the outputs for every cycle. Directed phases follow the buffer's
// key scenarios, and a randomized phase follows them.
module tb_instruction_buffer;
  localparam int IB_SZ = 8;
  localparam int CNT_W = $clog2(IB_SZ) + 1;
  localparam int PKT_W = 32;

  logic             clock;
  logic             reset;
  logic             squash;
  logic [CNT_W-1:0] ib_count;
  logic             full;
  logic             empty;
  logic             ovf_err;

  instruction_buffer_if #(.PKT_W(PKT_W)) bus ();

  instruction_buffer #(.IB_SZ(IB_SZ), .CNT_W(CNT_W), .PKT_W(PKT_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .squash   (squash),
    .bus      (bus),
    .ib_count (ib_count),
    .full     (full),
    .empty    (empty),
    .ovf_err  (ovf_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: the list of buffered packets, oldest first.
  logic [PKT_W-1:0] model_q [$];
  bit               model_ovf;

  int total_cnt;
  int pass_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_reset_outputs();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", bus.ib_ready, 1);
    check("rst_fire", bus.dp_fire, 0);
    check("rst_rob", bus.dp_rob_available, 0);
    check("rst_pkt", bus.dp_packet, 0);
    check("rst_count", ib_count, 0);
    check("rst_ovf", ovf_err, 0);
  endtask

  // One clock cycle: drive, check the combinational view against the model,
  // then advance the model across the edge.
  task automatic step(input bit v, input logic [PKT_W-1:0] p, input logic [1:0] rob,
                      input bit rs, input bit sq);
    bit m_empty, m_full, m_ready, m_fire;
    logic [PKT_W-1:0] m_pkt;
    @(negedge clock);
    bus.if_valid         = v;
    bus.if_packet        = p;
    bus.rob_dp_available = rob;
    bus.rs_available     = rs;
    squash               = sq;
    #1;
    m_empty = (model_q.size() == 0);
    m_full  = (model_q.size() == IB_SZ);
    m_ready = !m_full && !sq;
    m_fire  = !m_empty && !sq && rs && (rob != 2'b00);
    m_pkt   = m_empty ? '0 : model_q[0];
    check("count", ib_count, model_q.size());
    check("empty", empty, m_empty);
    check("full", full, m_full);
    check("ready", bus.ib_ready, m_ready);
    check("fire", bus.dp_fire, m_fire);
    check("rob_req", bus.dp_rob_available, {1'b0, m_fire});
    check("packet", bus.dp_packet, m_pkt);
    check("ovf", ovf_err, model_ovf);
    @(posedge clock);
    if (m_fire) $display("dispatch %08h (count %0d)", m_pkt, model_q.size());
    if (v && !m_ready && !sq) model_ovf = 1'b1;
    if (sq) begin
      model_q.delete();
    end else begin
      if (m_fire) void'(model_q.pop_front());
      if (v && m_ready) model_q.push_back(p);
    end
  endtask

  function automatic logic [PKT_W-1:0] rnd_pkt();
    return $urandom() | 32'h8000_0000;
  endfunction

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    model_ovf = 1'b0;
    bus.if_valid = 0; bus.if_packet = '0; bus.rob_dp_available = 0;
    bus.rs_available = 0; squash = 0;
    reset = 1'b1;
    #2;
    check_reset_outputs();
    @(negedge clock);
    reset = 1'b0;

    // Enqueue A, B, C with the reservation stations blocked.
    step(1, 32'hA000_000A, 2'b10, 0, 0);
    step(1, 32'hB000_000B, 2'b10, 0, 0);
    step(1, 32'hC000_000C, 2'b10, 0, 0);
    // Dispatch all three back to back, then observe the empty state.
    repeat (3) step(0, '0, 2'b10, 1, 0);
    step(0, '0, 2'b10, 1, 0);

    // Fill to full, keep pushing to trip the overflow flag.
    repeat (IB_SZ) step(1, rnd_pkt(), 2'b00, 1, 0);
    repeat (2) step(1, rnd_pkt(), 2'b00, 1, 0);
    step(1, rnd_pkt(), 2'b10, 1, 0);   // full and fire, with no enqueue
    step(0, '0, 2'b00, 0, 0);          // ready again, count 7

    // Drain to 4, then simultaneous enqueue and fire so that the pointers wrap.
    repeat (3) step(0, '0, 2'b01, 1, 0);
    repeat (20) step(1, rnd_pkt(), 2'b01, 1, 0);

    // Drain to 2. The ROB reports no space, then one slot.
    repeat (2) step(0, '0, 2'b10, 1, 0);
    repeat (2) step(0, '0, 2'b00, 1, 0);
    repeat (2) step(0, '0, 2'b01, 1, 0);

    // Fill to 5, then squash with a competing enqueue and dispatch.
    repeat (5) step(1, rnd_pkt(), 2'b00, 0, 0);
    step(1, rnd_pkt(), 2'b10, 1, 1);
    step(0, '0, 2'b10, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, rnd_pkt(), 2'($urandom_range(0, 2)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
    end

    // Build some occupancy, then assert reset in the middle of a cycle.
    repeat (4) step(1, rnd_pkt(), 2'b00, 0, 0);
    @(negedge clock);
    bus.if_valid = 0; bus.rs_available = 0; bus.rob_dp_available = 0; squash = 0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 2) != 0, rnd_pkt(), 2'($urandom_range(0, 2)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 50) == 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/instruction_buffer.md
# instruction_buffer

Circular FIFO of `DP_PACKET` entries between decode and dispatch. It absorbs decode bandwidth and presents the oldest instruction to the ROB and reservation stations. It dequeues only when both the ROB and the RS report space, and drives `instructions_buffer_rob_packet` together with the `dp_rob_available` request into the ROB. It supports a single-cycle squash on branch mispredict.

## Interface
- `IB_SZ`, 8: entry count; power of two, ≥2.
- `CNT_W`, `$clog2(IB_SZ)+1`: occupancy counter width.

- `clock`: input, 1, rising-edge clock.
- `reset`: input, 1, asynchronous, active-high.
- `squash`: input, 1, flush all entries (mispredict/exception).
- `if_valid`: input, 1, decode presents a packet this cycle.
- `if_packet`: input, `$bits(DP_PACKET)`, decoded instruction.
- `ib_ready`: output, 1, buffer accepts an enqueue this cycle.
- `rob_dp_available`: input, 2, ROB free slots (00 none, 01 one, 10 two or more).
- `rs_available`: input, 1, RS has a free entry.
- `dp_packet`: output, `$bits(DP_PACKET)`, head entry (show-ahead); drives `instructions_buffer_rob_packet`.
- `dp_rob_available`: output, 2, 2'b01 when a dispatch fires this cycle, else 2'b00.
- `dp_fire`: output, 1, head is dequeued at this clock edge.
- `ib_count`: output, `CNT_W`, current occupancy.
- `full`: output, 1, `ib_count == IB_SZ`.
- `empty`: output, 1, `ib_count == 0`.
- `ovf_err`: output, 1, sticky flag: `if_valid` seen while `ib_ready` is 0.

## Operation
- Storage: `IB_SZ` × `DP_PACKET` array; `head` and `tail` pointers of `$clog2(IB_SZ)` bits wrap naturally; `count` is `CNT_W` bits.
- `ib_ready = !full && !squash`. It is derived from registered `count` only; a same-cycle dequeue does not free a slot for enqueue.
- `enq = if_valid && ib_ready`. On enq: `mem[tail] <= if_packet`, `tail <= tail+1`.
- `dp_fire = !empty && !squash && rs_available && (rob_dp_available != 2'b00)`. On fire: `head <= head+1`.
- `dp_rob_available = {1'b0, dp_fire}`.
- `dp_packet = mem[head]` when `!empty`, else `'0`; the valid bit is therefore 0 when empty.
- Count update: `+1` on enq only, `-1` on fire only, unchanged on both or neither.
- Squash has priority over everything: `head`, `tail` and `count` go to 0 at the next edge; same-cycle `if_valid` is ignored and no fire occurs. Memory contents are left stale.
- `ovf_err` sets on `if_valid && !ib_ready && !squash`. It clears only on reset.
- No empty bypass: an enqueued packet is first visible on `dp_packet` the cycle after enq.
- Dispatch is strictly in order, at most one per cycle.

## Timing
- Reset (async, immediate): `head`=`tail`=`count`=0, all memory `'0`, `ovf_err`=0. Outputs during reset: `empty`=1, `full`=0, `ib_ready`=1, `dp_fire`=0, `dp_rob_available`=00, `dp_packet`='0, `ib_count`=0.
- Reset asserted mid-operation discards all entries. No packet is dispatched in the cycle reset deasserts unless one is enqueued first (minimum enq-to-fire latency is 1 cycle).
- Enq at edge N: `ib_count` increments and the packet is on `dp_packet` after edge N; the earliest fire is at edge N+1.
- Handshake: all fire inputs are sampled combinationally in the same cycle. The ROB and RS must capture `dp_packet` at the edge where `dp_fire`=1.
- Full: `ib_ready`=0, and a dequeue that cycle still proceeds. `ib_ready` returns to 1 one cycle after the first fire.
- Wrap-around: `tail` goes from `IB_SZ-1` to 0 and `head` likewise, with no bubble.

## Test plan
- Reset then enqueue A,B,C on 3 consecutive cycles with `rs_available`=0 -> `ib_count`=3, `dp_packet`=A, `dp_fire`=0 throughout.
- Set `rs_available`=1 and `rob_dp_available`=10 -> A, B, C fire on 3 consecutive edges with `dp_rob_available`=01 each cycle, then `empty`=1 and `dp_packet`='0.
- Fill 8 entries, hold `if_valid`=1 -> `full`=1, `ib_ready`=0, `ovf_err`=1 (sticky). Enable dispatch for 1 cycle -> count 7, `ib_ready`=1 the next cycle.
- Simultaneous enq and fire at count=4 for 20 cycles -> count stays 4, dispatch order matches enqueue order, and pointers wrap at least twice.
- `rob_dp_available`=00 with `rs_available`=1 and count=2 -> no fire. Change it to 01 -> one fire per cycle.
- Squash at count=5 with `if_valid`=1 and dispatch enabled -> next cycle count=0, `empty`=1, no fire during the squash cycle, and the squash-cycle packet is dropped. Assert reset mid-stream -> all outputs take their reset values immediately.
